// File: rtl/riscv_regfile_wb_scheduler.sv
// Writeback scheduler for the integer register file write port.
// Arbitrates ALU and LSU writebacks and tracks outstanding loads for issue stalls.
module riscv_regfile_wb_scheduler #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,

    input  logic            i_alu_wb_valid,
    input  logic [4:0]      i_alu_wb_rd_addr,
    input  logic [XLEN-1:0] i_alu_wb_data,
    output logic            o_alu_wb_ready,

    input  logic            i_lsu_wb_valid,
    input  logic [4:0]      i_lsu_wb_rd_addr,
    input  logic [XLEN-1:0] i_lsu_wb_data,
    output logic            o_lsu_wb_ready,

    input  logic            i_issue_valid,
    input  logic            i_issue_is_load,
    input  logic [4:0]      i_issue_rd_addr,
    input  logic [4:0]      i_issue_rs1_addr,
    input  logic [4:0]      i_issue_rs2_addr,
    output logic            o_issue_stall,

    input  logic            i_flush,

    output logic            o_regfile_rd_wen,
    output logic [4:0]      o_regfile_rd_addr,
    output logic [XLEN-1:0] o_regfile_rd_data,
    output logic [31:0]     o_busy_mask
);

    localparam int unsigned WaitW = 4;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    logic [WaitW-1:0] wait_q, wait_d;
    logic [31:0]      busy_q, busy_d;
    logic             wen_q, wen_d;
    logic [4:0]       addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             from_lsu_q, from_lsu_d;

    logic             alu_grant;
    logic             lsu_grant;
    logic             issue_set;

    // ALU only beats a pending LSU request once it has been starved MAX_WAIT cycles.
    always_comb begin
        alu_grant = i_alu_wb_valid && (!i_lsu_wb_valid || (wait_q == WaitMax));
        lsu_grant = i_lsu_wb_valid && !alu_grant;
    end

    assign o_alu_wb_ready = alu_grant;
    assign o_lsu_wb_ready = lsu_grant;

    always_comb begin
        wait_d = wait_q;
        if (!i_alu_wb_valid || alu_grant) begin
            wait_d = '0;
        end else if (wait_q != WaitMax) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        wen_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        from_lsu_d = 1'b0;
        if (alu_grant) begin
            wen_d  = (i_alu_wb_rd_addr != 5'd0);
            addr_d = i_alu_wb_rd_addr;
            data_d = i_alu_wb_data;
        end else if (lsu_grant) begin
            wen_d      = (i_lsu_wb_rd_addr != 5'd0);
            addr_d     = i_lsu_wb_rd_addr;
            data_d     = i_lsu_wb_data;
            from_lsu_d = 1'b1;
        end
    end

    assign o_issue_stall = i_issue_valid &&
                           (busy_q[i_issue_rs1_addr] || busy_q[i_issue_rs2_addr] ||
                            busy_q[i_issue_rd_addr]);

    assign issue_set = i_issue_valid && !o_issue_stall && i_issue_is_load &&
                       (i_issue_rd_addr != 5'd0);

    // Ordering gives set priority over clear and flush priority over both.
    always_comb begin
        busy_d = busy_q;
        if (wen_q && from_lsu_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[i_issue_rd_addr] = 1'b1;
        end
        if (i_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wait_q     <= '0;
            busy_q     <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            from_lsu_q <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            from_lsu_q <= from_lsu_d;
        end
    end

    assign o_regfile_rd_wen  = wen_q;
    assign o_regfile_rd_addr = addr_q;
    assign o_regfile_rd_data = data_q;
    assign o_busy_mask       = busy_q;

endmodule

// File: tb/tb_riscv_regfile_wb_scheduler.sv
// Directed bench for riscv_regfile_wb_scheduler: arbitration, write port, scoreboard,
// flush and asynchronous reset.
module tb_riscv_regfile_wb_scheduler;

    logic        i_clk;
    logic        i_rstn;
    logic        i_alu_wb_valid;
    logic [4:0]  i_alu_wb_rd_addr;
    logic [31:0] i_alu_wb_data;
    logic        o_alu_wb_ready;
    logic        i_lsu_wb_valid;
    logic [4:0]  i_lsu_wb_rd_addr;
    logic [31:0] i_lsu_wb_data;
    logic        o_lsu_wb_ready;
    logic        i_issue_valid;
    logic        i_issue_is_load;
    logic [4:0]  i_issue_rd_addr;
    logic [4:0]  i_issue_rs1_addr;
    logic [4:0]  i_issue_rs2_addr;
    logic        o_issue_stall;
    logic        i_flush;
    logic        o_regfile_rd_wen;
    logic [4:0]  o_regfile_rd_addr;
    logic [31:0] o_regfile_rd_data;
    logic [31:0] o_busy_mask;

    int checks;
    int failures;

    riscv_regfile_wb_scheduler #(
        .XLEN     (32),
        .MAX_WAIT (4)
    ) dut (
        .i_clk             (i_clk),
        .i_rstn            (i_rstn),
        .i_alu_wb_valid    (i_alu_wb_valid),
        .i_alu_wb_rd_addr  (i_alu_wb_rd_addr),
        .i_alu_wb_data     (i_alu_wb_data),
        .o_alu_wb_ready    (o_alu_wb_ready),
        .i_lsu_wb_valid    (i_lsu_wb_valid),
        .i_lsu_wb_rd_addr  (i_lsu_wb_rd_addr),
        .i_lsu_wb_data     (i_lsu_wb_data),
        .o_lsu_wb_ready    (o_lsu_wb_ready),
        .i_issue_valid     (i_issue_valid),
        .i_issue_is_load   (i_issue_is_load),
        .i_issue_rd_addr   (i_issue_rd_addr),
        .i_issue_rs1_addr  (i_issue_rs1_addr),
        .i_issue_rs2_addr  (i_issue_rs2_addr),
        .o_issue_stall     (o_issue_stall),
        .i_flush           (i_flush),
        .o_regfile_rd_wen  (o_regfile_rd_wen),
        .o_regfile_rd_addr (o_regfile_rd_addr),
        .o_regfile_rd_data (o_regfile_rd_data),
        .o_busy_mask       (o_busy_mask)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rstn           = 1'b0;
        i_alu_wb_valid   = 1'b0;
        i_alu_wb_rd_addr = '0;
        i_alu_wb_data    = '0;
        i_lsu_wb_valid   = 1'b0;
        i_lsu_wb_rd_addr = '0;
        i_lsu_wb_data    = '0;
        i_issue_valid    = 1'b0;
        i_issue_is_load  = 1'b0;
        i_issue_rd_addr  = '0;
        i_issue_rs1_addr = '0;
        i_issue_rs2_addr = '0;
        i_flush          = 1'b0;
        #12;
        checks++;
        if (o_regfile_rd_wen !== 1'b0) begin
            failures++;
            $display("FAIL reset_wen: got %b expected 0", o_regfile_rd_wen);
        end
        checks++;
        if (o_regfile_rd_addr !== 5'd0 || o_regfile_rd_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_addr_data: got %0d/%h expected 0/00000000",
                     o_regfile_rd_addr, o_regfile_rd_data);
        end
        checks++;
        if (o_busy_mask !== 32'd0) begin
            failures++;
            $display("FAIL reset_busy: got %h expected 00000000", o_busy_mask);
        end
        checks++;
        if (o_alu_wb_ready !== 1'b0 || o_lsu_wb_ready !== 1'b0 || o_issue_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_outputs: got alu_rdy=%b lsu_rdy=%b stall=%b expected 0/0/0",
                     o_alu_wb_ready, o_lsu_wb_ready, o_issue_stall);
        end
        #1 i_rstn = 1'b1;
        tick();
    endtask

    task automatic test_alu_single();
        i_alu_wb_valid   = 1'b1;
        i_alu_wb_rd_addr = 5'd5;
        i_alu_wb_data    = 32'h1234;
        #1;
        checks++;
        if (o_alu_wb_ready !== 1'b1 || o_lsu_wb_ready !== 1'b0) begin
            failures++;
            $display("FAIL alu_single_ready: got alu=%b lsu=%b expected 1/0",
                     o_alu_wb_ready, o_lsu_wb_ready);
        end
        tick();
        i_alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (o_regfile_rd_wen !== 1'b1 || o_regfile_rd_addr !== 5'd5 ||
            o_regfile_rd_data !== 32'h00001234) begin
            failures++;
            $display("FAIL alu_single_write: got wen=%b addr=%0d data=%h expected 1/5/00001234",
                     o_regfile_rd_wen, o_regfile_rd_addr, o_regfile_rd_data);
        end
        tick();
        checks++;
        if (o_regfile_rd_wen !== 1'b0 || o_regfile_rd_addr !== 5'd5 ||
            o_regfile_rd_data !== 32'h00001234) begin
            failures++;
            $display("FAIL alu_single_hold: got wen=%b addr=%0d data=%h expected 0/5/00001234",
                     o_regfile_rd_wen, o_regfile_rd_addr, o_regfile_rd_data);
        end
    endtask

    task automatic test_arbitration();
        // bit i set => LSU wins cycle i: four LSU grants, ALU on the fifth, then LSU again
        logic [5:0] lsu_pat;
        lsu_pat          = 6'b101111;
        i_alu_wb_valid   = 1'b1;
        i_alu_wb_rd_addr = 5'd10;
        i_alu_wb_data    = 32'h0000000A;
        i_lsu_wb_valid   = 1'b1;
        i_lsu_wb_rd_addr = 5'd9;
        i_lsu_wb_data    = 32'hDEAD0009;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (o_lsu_wb_ready !== lsu_pat[i] || o_alu_wb_ready !== !lsu_pat[i]) begin
                failures++;
                $display("FAIL arb_grant_%0d: got alu=%b lsu=%b expected alu=%b lsu=%b",
                         i, o_alu_wb_ready, o_lsu_wb_ready, !lsu_pat[i], lsu_pat[i]);
            end
            tick();
            checks++;
            if (o_regfile_rd_wen !== 1'b1 ||
                o_regfile_rd_addr !== (lsu_pat[i] ? 5'd9 : 5'd10) ||
                o_regfile_rd_data !== (lsu_pat[i] ? 32'hDEAD0009 : 32'h0000000A)) begin
                failures++;
                $display("FAIL arb_write_%0d: got wen=%b addr=%0d data=%h expected winner %s",
                         i, o_regfile_rd_wen, o_regfile_rd_addr, o_regfile_rd_data,
                         lsu_pat[i] ? "lsu" : "alu");
            end
        end
        i_alu_wb_valid = 1'b0;
        i_lsu_wb_valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        i_issue_valid    = 1'b1;
        i_issue_is_load  = 1'b1;
        i_issue_rd_addr  = 5'd7;
        i_issue_rs1_addr = 5'd0;
        i_issue_rs2_addr = 5'd0;
        #1;
        checks++;
        if (o_issue_stall !== 1'b0) begin
            failures++;
            $display("FAIL sb_load_no_stall: got %b expected 0", o_issue_stall);
        end
        tick();
        i_issue_valid = 1'b0;
        #1;
        checks++;
        if (o_busy_mask !== 32'h00000080) begin
            failures++;
            $display("FAIL sb_set: got %h expected 00000080", o_busy_mask);
        end
        i_issue_valid    = 1'b1;
        i_issue_is_load  = 1'b0;
        i_issue_rd_addr  = 5'd1;
        i_issue_rs1_addr = 5'd7;
        i_issue_rs2_addr = 5'd2;
        i_lsu_wb_valid   = 1'b1;
        i_lsu_wb_rd_addr = 5'd7;
        i_lsu_wb_data    = 32'h00000077;
        #1;
        checks++;
        if (o_issue_stall !== 1'b1 || o_lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL sb_raw_stall: got stall=%b lsu_rdy=%b expected 1/1",
                     o_issue_stall, o_lsu_wb_ready);
        end
        tick();
        i_lsu_wb_valid = 1'b0;
        #1;
        checks++;
        if (o_regfile_rd_wen !== 1'b1 || o_regfile_rd_addr !== 5'd7 ||
            o_busy_mask !== 32'h00000080 || o_issue_stall !== 1'b1) begin
            failures++;
            $display("FAIL sb_wb_cycle: got wen=%b addr=%0d busy=%h stall=%b expected 1/7/00000080/1",
                     o_regfile_rd_wen, o_regfile_rd_addr, o_busy_mask, o_issue_stall);
        end
        tick();
        checks++;
        if (o_busy_mask !== 32'd0 || o_issue_stall !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear: got busy=%h stall=%b expected 00000000/0",
                     o_busy_mask, o_issue_stall);
        end
        i_issue_valid    = 1'b0;
        i_issue_rs1_addr = 5'd0;
        i_issue_rs2_addr = 5'd0;
    endtask

    task automatic test_x0();
        i_lsu_wb_valid   = 1'b1;
        i_lsu_wb_rd_addr = 5'd0;
        i_lsu_wb_data    = 32'hFFFFFFFF;
        #1;
        checks++;
        if (o_lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready: got %b expected 1", o_lsu_wb_ready);
        end
        tick();
        i_lsu_wb_valid = 1'b0;
        #1;
        checks++;
        if (o_regfile_rd_wen !== 1'b0) begin
            failures++;
            $display("FAIL x0_no_write: got wen=%b expected 0", o_regfile_rd_wen);
        end
        i_issue_valid   = 1'b1;
        i_issue_is_load = 1'b1;
        i_issue_rd_addr = 5'd0;
        tick();
        i_issue_valid = 1'b0;
        #1;
        checks++;
        if (o_busy_mask !== 32'd0) begin
            failures++;
            $display("FAIL x0_load_busy: got %h expected 00000000", o_busy_mask);
        end
    endtask

    task automatic test_flush();
        i_issue_valid   = 1'b1;
        i_issue_is_load = 1'b1;
        i_issue_rd_addr = 5'd7;
        tick();
        i_issue_rd_addr = 5'd8;
        tick();
        i_issue_valid = 1'b0;
        #1;
        checks++;
        if (o_busy_mask !== 32'h00000180) begin
            failures++;
            $display("FAIL flush_pre_busy: got %h expected 00000180", o_busy_mask);
        end
        i_alu_wb_valid   = 1'b1;
        i_alu_wb_rd_addr = 5'd12;
        i_alu_wb_data    = 32'h0000ABCD;
        tick();
        i_alu_wb_valid   = 1'b0;
        i_flush          = 1'b1;
        i_issue_valid    = 1'b1;
        i_issue_is_load  = 1'b1;
        i_issue_rd_addr  = 5'd3;
        i_lsu_wb_valid   = 1'b1;
        i_lsu_wb_rd_addr = 5'd8;
        i_lsu_wb_data    = 32'h00000088;
        #1;
        checks++;
        if (o_regfile_rd_wen !== 1'b1 || o_regfile_rd_addr !== 5'd12 ||
            o_regfile_rd_data !== 32'h0000ABCD || o_lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_inflight_alu: got wen=%b addr=%0d data=%h lsu_rdy=%b expected 1/12/0000abcd/1",
                     o_regfile_rd_wen, o_regfile_rd_addr, o_regfile_rd_data, o_lsu_wb_ready);
        end
        tick();
        i_flush        = 1'b0;
        i_issue_valid  = 1'b0;
        i_lsu_wb_valid = 1'b0;
        #1;
        checks++;
        if (o_busy_mask !== 32'd0) begin
            failures++;
            $display("FAIL flush_clear: got %h expected 00000000", o_busy_mask);
        end
        checks++;
        if (o_regfile_rd_wen !== 1'b1 || o_regfile_rd_addr !== 5'd8 ||
            o_regfile_rd_data !== 32'h00000088) begin
            failures++;
            $display("FAIL flush_accepted_lsu: got wen=%b addr=%0d data=%h expected 1/8/00000088",
                     o_regfile_rd_wen, o_regfile_rd_addr, o_regfile_rd_data);
        end
        tick();
    endtask

    task automatic test_async_reset();
        i_alu_wb_valid   = 1'b1;
        i_alu_wb_rd_addr = 5'd20;
        i_alu_wb_data    = 32'h00000055;
        i_issue_valid    = 1'b1;
        i_issue_is_load  = 1'b1;
        i_issue_rd_addr  = 5'd4;
        tick();
        i_alu_wb_valid = 1'b0;
        i_issue_valid  = 1'b0;
        #1;
        checks++;
        if (o_regfile_rd_wen !== 1'b1 || o_regfile_rd_addr !== 5'd20 ||
            o_busy_mask !== 32'h00000010) begin
            failures++;
            $display("FAIL arst_setup: got wen=%b addr=%0d busy=%h expected 1/20/00000010",
                     o_regfile_rd_wen, o_regfile_rd_addr, o_busy_mask);
        end
        #1 i_rstn = 1'b0;
        #1;
        checks++;
        if (o_regfile_rd_wen !== 1'b0 || o_regfile_rd_addr !== 5'd0 ||
            o_regfile_rd_data !== 32'd0 || o_busy_mask !== 32'd0) begin
            failures++;
            $display("FAIL arst_immediate: got wen=%b addr=%0d data=%h busy=%h expected all 0",
                     o_regfile_rd_wen, o_regfile_rd_addr, o_regfile_rd_data, o_busy_mask);
        end
        #2 i_rstn = 1'b1;
        tick();
        checks++;
        if (o_regfile_rd_wen !== 1'b0 || o_busy_mask !== 32'd0) begin
            failures++;
            $display("FAIL arst_release: got wen=%b busy=%h expected 0/00000000",
                     o_regfile_rd_wen, o_busy_mask);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_single();
        test_arbitration();
        test_scoreboard();
        test_x0();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_regfile_wb_scheduler.md
Name: riscv_regfile_wb_scheduler

Overview:
Schedules the single write port of the integer register file between two writeback requesters: the ALU path and the load/store unit (LSU).
Also keeps a per-register busy scoreboard for outstanding loads, and stalls issue on RAW or WAW hazards against those loads.
Sits between execute/LSU writeback and the register file write port, and feeds the stall input of the issue stage.

Parameters:
XLEN, 32, data width of register file entries.
MAX_WAIT, 4, consecutive cycles the ALU can be denied before it is forced to win arbitration (range 1..15).

Ports:
i_clk  input  1  clock
i_rstn  input  1  asynchronous active-low reset
i_alu_wb_valid  input  1  ALU writeback request
i_alu_wb_rd_addr  input  5  ALU destination register
i_alu_wb_data  input  XLEN  ALU result
o_alu_wb_ready  output  1  ALU request accepted this cycle (combinational)
i_lsu_wb_valid  input  1  LSU writeback request
i_lsu_wb_rd_addr  input  5  LSU destination register
i_lsu_wb_data  input  XLEN  load data
o_lsu_wb_ready  output  1  LSU request accepted this cycle (combinational)
i_issue_valid  input  1  instruction presented at issue
i_issue_is_load  input  1  issued instruction is a load
i_issue_rd_addr  input  5  issued destination register
i_issue_rs1_addr  input  5  issued source 1
i_issue_rs2_addr  input  5  issued source 2
o_issue_stall  output  1  hazard; issue must hold (combinational)
i_flush  input  1  pipeline flush; clears scoreboard
o_regfile_rd_wen  output  1  register file write enable (registered)
o_regfile_rd_addr  output  5  register file write address (registered)
o_regfile_rd_data  output  XLEN  register file write data (registered)
o_busy_mask  output  32  scoreboard busy bits, bit n = xn

Behaviour:
- Reset (async, i_rstn=0): o_regfile_rd_wen=0, o_regfile_rd_addr=0, o_regfile_rd_data=0, busy mask=0, wait counter=0.
- Handshake: a request is accepted on the rising edge where valid && ready. At most one of the two ready outputs is high in any cycle. A ready output is never high while its valid is low.
- Arbitration:
  - LSU wins by default.
  - If wait_cnt == MAX_WAIT and ALU is valid, ALU wins instead.
  - If only one requester is valid, it wins.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle the ALU is valid but not granted.
  - Clears on ALU acceptance.
  - Clears in any cycle the ALU is not valid.
- Write port latency is 1 cycle: the accepted request appears on o_regfile_rd_* in the next cycle, with wen=1 for exactly one cycle.
- If no request is accepted, wen=0 next cycle; addr and data hold their previous values.
- An accepted request with rd=0 is consumed and produces wen=0 (x0 is never written).
- Scoreboard set: on an edge where i_issue_valid && !o_issue_stall && i_issue_is_load && rd!=0, busy[rd] is set.
- Scoreboard clear: on the edge ending a cycle where o_regfile_rd_wen=1 and the write came from the LSU, busy[o_regfile_rd_addr] is cleared.
- Simultaneous set and clear of the same register: set wins.
- i_flush: clears all busy bits on the next edge and overrides any set in that cycle. Writes already accepted or registered complete normally, and the wait counter is unaffected.
- o_issue_stall = i_issue_valid && (busy[rs1] || busy[rs2] || busy[rd]). busy[0] is always 0, so x0 never causes a stall.
- o_busy_mask reflects the registered scoreboard state.
- Requesters must hold valid, addr and data stable until accepted.

Test Plan:
- Reset, then ALU valid alone with rd=5, data=0x1234 -> o_alu_wb_ready=1; next cycle wen=1, addr=5, data=0x00001234; following cycle wen=0.
- ALU and LSU both valid continuously, MAX_WAIT=4 -> LSU granted 4 cycles, ALU granted on the 5th cycle, wait counter returns to 0, LSU granted again.
- Issue a load with rd=7 -> busy mask=0x00000080. Then issue with rs1=7 -> stall=1. LSU writeback rd=7 accepted -> busy[7] clears one cycle after wen; stall drops in that cycle.
- LSU writeback rd=0, data=0xFFFFFFFF -> ready=1 but wen stays 0; a load issued with rd=0 leaves the busy mask at 0.
- Busy mask 0x00000180, assert i_flush while issuing a load rd=3 -> busy mask=0 next cycle, and the in-flight registered write still completes.
- Drop i_rstn mid-transfer while wen=1 -> wen, addr, data and busy mask go to 0 immediately, without waiting for a clock edge.
